// File: rtl/mem_copier_if.sv
// Split-phase 32-bit memory bus: request/ack for address phase, resp carries read data.
// Latency: set by the slave; ack completes a request, resp arrives at least one cycle after a read ack.
// Backpressure: slave stalls the master by holding ack low; the master keeps req and payload stable.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/mem_copier.sv
// Word-by-word block copier over MemSplit32 (read, wait resp, write); MEM_COPIER_FILL_EN adds a pattern-fill mode.
// Latency: 3 cycles per copied word (1 per filled word) against a zero-wait slave, plus one FINISH cycle.
// Backpressure: holds req/addr/we/wdata stable until ack; abort only takes effect at a handshake boundary.
module mem_copier #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
`ifdef MEM_COPIER_FILL_EN
    input  logic             fill_i,
    input  logic [31:0]      fill_data_i,
`endif
    MemSplit32.Master        bus,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] count_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic             abort_q;
    logic             abort_pend;
    logic             last_word;
    logic             fill_start;
    logic             fill_q;
    logic             active;

`ifdef MEM_COPIER_FILL_EN
    assign fill_start = fill_i;
`else
    assign fill_start = 1'b0;
    assign fill_q     = 1'b0;
`endif

    assign active     = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    assign abort_pend = abort_q | abort_i;
    assign last_word  = (count_q + LEN_W'(1)) == len_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0)     state_d = FINISH;
                    else if (fill_start) state_d = WR_REQ;
                    else                 state_d = RD_REQ;
                end
            end
            // An abort seen before the read ack still waits for its resp so no
            // read data is left in flight on the bus when we report done.
            RD_REQ:  if (bus.ack)  state_d = RD_WAIT;
            RD_WAIT: if (bus.resp) state_d = abort_pend ? FINISH : WR_REQ;
            WR_REQ: begin
                if (bus.ack) begin
                    if (abort_pend || last_word) state_d = FINISH;
                    else if (fill_q)             state_d = WR_REQ;
                    else                         state_d = RD_REQ;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            abort_q <= 1'b0;
`ifdef MEM_COPIER_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                src_q   <= src_addr_i;
                dst_q   <= dst_addr_i;
                len_q   <= len_i;
                count_q <= '0;
                abort_q <= 1'b0;
`ifdef MEM_COPIER_FILL_EN
                fill_q  <= fill_i;
                if (fill_i) data_q <= fill_data_i;
`endif
            end
            if (active && abort_i) abort_q <= 1'b1;
            if (state_q == RD_WAIT && bus.resp) data_q <= bus.rdata;
            if (state_q == WR_REQ && bus.ack) begin
                src_q   <= src_q + ADDR_STEP;
                dst_q   <= dst_q + ADDR_STEP;
                count_q <= count_q + LEN_W'(1);
            end
        end
    end

    assign bus.req   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus.we    = (state_q == WR_REQ);
    assign bus.addr  = (state_q == WR_REQ) ? dst_q : src_q;
    assign bus.be    = bus.req ? 4'hF : 4'h0;
    assign bus.wdata = data_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == FINISH);
    assign count_o   = count_q;

endmodule

// File: tb/tb_mem_copier.sv
// Scoreboarded bench for mem_copier against a configurable-latency split-phase memory model.
module tb_mem_copier;
    localparam int LEN_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_v;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
`ifdef MEM_COPIER_FILL_EN
    logic             fill;
    logic [31:0]      fill_data;
`endif

    MemSplit32 bus_if ();

    mem_copier #(.LEN_W(LEN_W), .ADDR_STEP(32'd4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len_v),
        .abort_i    (abort),
`ifdef MEM_COPIER_FILL_EN
        .fill_i     (fill),
        .fill_data_i(fill_data),
`endif
        .bus        (bus_if),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory slave model and scoreboard
    logic [31:0] mem [256];
    wr_t         exp_q [$];
    int          ack_delay = 0, resp_delay = 0, wait_cnt = 0, resp_cnt = 0;
    bit          rd_pend = 1'b0, stray_resp = 1'b0;
    logic [7:0]  rd_idx;
    int          reads, writes, resps, unstable, req_cyc, busy_cyc;
    int          cyc = 0, wr_cyc = 0, done_cyc = 0;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t e;
        bus_if.ack   = 1'b0;
        bus_if.resp  = stray_resp;
        bus_if.rdata = $urandom;
        if (rd_pend) begin
            if (resp_cnt == 0) begin
                bus_if.resp  = 1'b1;
                bus_if.rdata = mem[rd_idx];
                rd_pend      = 1'b0;
                resps++;
            end else begin
                resp_cnt--;
            end
        end
        if (bus_if.req === 1'b1) begin
            req_cyc++;
            if (wait_cnt == 0) begin
                s_addr  = bus_if.addr;
                s_we    = bus_if.we;
                s_wdata = bus_if.wdata;
            end else if (bus_if.addr !== s_addr || bus_if.we !== s_we ||
                         (s_we && bus_if.wdata !== s_wdata)) begin
                unstable++;
            end
            if (wait_cnt >= ack_delay) begin
                bus_if.ack = 1'b1;
                wait_cnt   = 0;
                if (bus_if.we) begin
                    writes++;
                    wr_cyc = cyc;
                    mem[bus_if.addr[9:2]] = bus_if.wdata;
                    check("wr_be", {28'd0, bus_if.be}, 32'h0000_000F);
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus_if.addr, e.addr);
                        check("wr_data", bus_if.wdata, e.data);
                    end
                end else begin
                    reads++;
                    rd_pend  = 1'b1;
                    rd_idx   = bus_if.addr[9:2];
                    resp_cnt = resp_delay;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (busy) busy_cyc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        reads = 0; writes = 0; resps = 0; unstable = 0; req_cyc = 0; busy_cyc = 0;
    endtask

    // Loads source words mult*(i+1), expects the first n_exp of them at dst, then pulses start.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input int n_exp, input logic [31:0] mult, input int ad, input int rd);
        wr_t e;
        ack_delay  = ad;
        resp_delay = rd;
        for (int i = 0; i < n; i++) mem[8'((src >> 2) + 32'(i))] = mult * 32'(i + 1);
        for (int i = 0; i < n_exp; i++) begin
            e.addr = dst + 32'(4 * i);
            e.data = mult * 32'(i + 1);
            exp_q.push_back(e);
        end
        clear_counts();
        src_addr = src;
        dst_addr = dst;
        len_v    = LEN_W'(n);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        done_cyc = cyc;
        step();
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_v = '0;
`ifdef MEM_COPIER_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_req", {31'd0, bus_if.req}, 32'd0);
        check("rst_we", {31'd0, bus_if.we}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", bus_if.addr, 32'd0);
        check("rst_wdata", bus_if.wdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic copy, zero-wait slave: 0x11, 0x22, 0x33
        run_copy(32'h100, 32'h200, 3, 3, 32'h11, 0, 0);
        wait_done("copy3");
        check("copy3_count", 32'(count), 32'd3);
        check("copy3_writes", 32'(writes), 32'd3);
        check("copy3_reads", 32'(reads), 32'd3);
        check("copy3_busy_cycles", 32'(busy_cyc), 32'd10);
        check("copy3_done_after_ack", 32'(done_cyc - wr_cyc), 32'd1);
        check("copy3_exp_left", 32'(exp_q.size()), 32'd0);

        // Zero-length transfer
        run_copy(32'h100, 32'h200, 0, 0, 32'h11, 0, 0);
        wait_done("len0");
        check("len0_req_cycles", 32'(req_cyc), 32'd0);
        check("len0_busy_cycles", 32'(busy_cyc), 32'd1);
        check("len0_count", 32'(count), 32'd0);

        // Slow slave, plus a start pulse mid-transfer that must be ignored
        run_copy(32'h300, 32'h380, 2, 2, 32'h0101_0101, 4, 3);
        repeat (3) step();
        src_addr = 32'h0; dst_addr = 32'h3C0; len_v = LEN_W'(7);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("slow");
        check("slow_stable", 32'(unstable), 32'd0);
        check("slow_writes", 32'(writes), 32'd2);
        check("slow_reads", 32'(reads), 32'd2);
        check("slow_count", 32'(count), 32'd2);
        check("slow_exp_left", 32'(exp_q.size()), 32'd0);

`ifdef MEM_COPIER_FILL_EN
        // Fill mode: pattern written to dst, no reads
        fill = 1'b1; fill_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'h40 + 32'(4 * i), data: 32'hDEAD_BEEF});
        run_copy(32'h0, 32'h40, 4, 0, 32'h0, 0, 0);
        fill = 1'b0;
        wait_done("fill");
        check("fill_reads", 32'(reads), 32'd0);
        check("fill_writes", 32'(writes), 32'd4);
        check("fill_busy_cycles", 32'(busy_cyc), 32'd5);
        check("fill_count", 32'(count), 32'd4);
        check("fill_exp_left", 32'(exp_q.size()), 32'd0);
`endif

        // Abort in RD_WAIT of word 2 of 5
        run_copy(32'h000, 32'h080, 5, 1, 32'h0000_00A5, 0, 2);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (count == LEN_W'(1) && busy && !bus_if.req && !done) begin
                abort = 1'b1;
                hit   = 1'b1;
            end
            step();
            abort = 1'b0;
        end
        check("abrd_window_found", {31'd0, hit}, 32'd1);
        wait_done("abrd");
        check("abrd_count", 32'(count), 32'd1);
        check("abrd_writes", 32'(writes), 32'd1);
        check("abrd_reads", 32'(reads), 32'd2);
        check("abrd_resps", 32'(resps), 32'd2);
        check("abrd_exp_left", 32'(exp_q.size()), 32'd0);

        // Abort in WR_REQ of word 1 while ack is stalled: write completes, then stop
        run_copy(32'h040, 32'h0C0, 4, 1, 32'h1234_0001, 3, 0);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (bus_if.req && bus_if.we) begin
                abort = 1'b1;
                hit   = 1'b1;
            end
            step();
            abort = 1'b0;
        end
        check("abwr_window_found", {31'd0, hit}, 32'd1);
        wait_done("abwr");
        check("abwr_count", 32'(count), 32'd1);
        check("abwr_writes", 32'(writes), 32'd1);
        check("abwr_reads", 32'(reads), 32'd1);
        check("abwr_stable", 32'(unstable), 32'd0);

        // Abort while idle does nothing
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("abidle_busy", {31'd0, busy}, 32'd0);
        check("abidle_count", 32'(count), 32'd1);

        // Reset during WR_REQ, then a stray resp while idle
        run_copy(32'h100, 32'h240, 4, 0, 32'h5555_0001, 3, 0);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (bus_if.req && bus_if.we) hit = 1'b1;
            else step();
        end
        check("rstmid_window_found", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_req", {31'd0, bus_if.req}, 32'd0);
        check("rstmid_count", 32'(count), 32'd0);
        clear_counts();
        stray_resp = 1'b1;
        step();
        stray_resp = 1'b0;
        repeat (10) step();
        check("rstmid_req_cycles", 32'(req_cyc), 32'd0);
        check("rstmid_writes", 32'(writes), 32'd0);
        check("rstmid_busy_cycles", 32'(busy_cyc), 32'd0);
        check("rstmid_count_after", 32'(count), 32'd0);
        check("rstmid_wdata", bus_if.wdata, 32'd0);
        check("rstmid_addr", bus_if.addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
